// File: rtl/sum_result_buffer.sv
// Show-ahead result FIFO behind the registered adder: absorbs bursts, counts drops when full,
// and keeps a clearable wrap-around running sum of every accepted result.
module sum_result_buffer #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  parameter  int ACC_W = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [7:0]       drop_cnt,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_drop_cnt;
  logic [ACC_W-1:0] r_acc;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees the head slot on the same edge, so a push into a full FIFO is still accepted.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= w_push ? ACC_W'(in_data) : '0;
    end else if (w_push) begin
      r_acc <= r_acc + ACC_W'(in_data);
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_cnt  = r_drop_cnt;
  assign acc       = r_acc;

endmodule

// File: tb/tb_sum_result_buffer.sv
// Bench for sum_result_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sum_result_buffer;

  localparam int W       = 10;
  localparam int DEPTH   = 4;
  localparam int ACC_W   = 10;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int ACC_MOD = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [7:0]       drop_cnt;
  logic             acc_clr = 1'b0;
  logic [ACC_W-1:0] acc;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int q[$];
  int m_drop = 0;
  int m_acc  = 0;

  sum_result_buffer #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt),
    .acc_clr(acc_clr), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_drop = 0;
      m_acc  = 0;
    end else begin
      bit pop, push, is_full;
      is_full = (q.size() == DEPTH);
      pop     = (q.size() != 0) && out_ready;
      push    = in_valid && (!is_full || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(in_data));
      if (in_valid && !push && m_drop < 255) m_drop++;
      if (acc_clr) m_acc = push ? int'(in_data) : 0;
      else if (push) m_acc = (m_acc + int'(in_data)) % ACC_MOD;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) chk("out_data", int'(out_data), q[0]);
    chk("count", int'(count), q.size());
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("acc", int'(acc), m_acc);
  end

  task automatic step(input bit v, input int d, input bit r, input bit c);
    in_valid  = v;
    in_data   = W'(d);
    out_ready = r;
    acc_clr   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_acc", int'(acc), 0);
    rst = 1'b0;

    // single result
    step(1, 'h123, 0, 0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 'h123);
    chk("t1_count", int'(count), 1);
    chk("t1_acc", int'(acc), 'h123);
    step(0, 0, 1, 0);
    chk("t1_empty", int'(empty), 1);

    // fill and drop
    step(0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) step(1, i, 0, 0);
    chk("t2_full", int'(full), 1);
    chk("t2_count", int'(count), 4);
    chk("t2_drop", int'(drop_cnt), 2);
    chk("t2_acc", int'(acc), 10);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", int'(out_data), i);
      step(0, 0, 1, 0);
    end
    chk("t2_empty", int'(empty), 1);

    // full with simultaneous push/pop
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
    step(1, 9, 1, 0);
    chk("t3_count", int'(count), 4);
    chk("t3_drop", int'(drop_cnt), 2);
    for (int i = 0; i < 4; i++) begin
      int exp_v [4] = '{2, 3, 4, 9};
      chk("t3_drain", int'(out_data), exp_v[i]);
      step(0, 0, 1, 0);
    end

    // streaming across pointer wrap
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, i, 1, 0);
      chk("t4_data", int'(out_data), i);
      chk("t4_count", int'(count), 1);
    end
    step(0, 0, 1, 0);
    chk("t4_acc", int'(acc), 190);

    // accumulator wrap and clear
    step(0, 0, 0, 1);
    step(1, 'h3FF, 1, 0);
    step(1, 'h3FF, 1, 0);
    chk("t5_wrap", int'(acc), 'h3FE);
    step(1, 5, 1, 1);
    chk("t5_clr_push", int'(acc), 5);
    step(0, 0, 1, 1);
    chk("t5_clr", int'(acc), 0);

    // async reset mid-operation with count=3, drop_cnt=7
    for (int i = 0; i < 9; i++) step(1, 'h40 + i, 0, 0);
    step(0, 0, 1, 0);
    chk("t6_pre_count", int'(count), 3);
    chk("t6_pre_drop", int'(drop_cnt), 7);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_count", int'(count), 0);
    chk("t6_drop", int'(drop_cnt), 0);
    chk("t6_acc", int'(acc), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1, 'h055, 0, 0);
    chk("t6_data", int'(out_data), 'h055);
    chk("t6_cnt1", int'(count), 1);

    // drop counter saturation
    for (int i = 0; i < 265; i++) step(1, i, 0, 0);
    chk("sat_drop", int'(drop_cnt), 255);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    step(0, 0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_result_buffer.md
# sum_result_buffer

Result-side stage sitting directly downstream of the registered adder: captures each `valid`/`y` result pulse into a small show-ahead FIFO and presents results to a consumer over a valid/ready handshake. The adder has no backpressure, so the buffer absorbs bursts, drops results it cannot hold and counts the drops. It also keeps a running wrap-around accumulation of every accepted result, which the consumer can clear.

## Interface
- `W`, 10: result data width; must match the adder width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ACC_W`, 16: accumulator width; ACC_W ≥ W.
- `CW` (localparam), $clog2(DEPTH+1): width of `count`.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  result strobe from the adder (`valid`).
- `in_data`  in  W  result value from the adder (`y`).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `out_data`  out  W  head entry; meaningful only when `out_valid` is 1.
- `count`  out  CW  number of stored entries, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `drop_cnt`  out  8  number of dropped results; saturates at 255.
- `acc_clr`  in  1  synchronous clear of `acc`.
- `acc`  out  ACC_W  running sum of accepted results, modulo 2^ACC_W.

## Operation
- Storage: DEPTH×W register array, write pointer `wr_ptr` and read pointer `rd_ptr` (log2(DEPTH) bits, natural wrap), plus a `count` register.
- Pop: `pop = out_valid & out_ready`. Advances `rd_ptr` by 1.
- Push: `push = in_valid & (!full | pop)`. Writes `in_data` at `wr_ptr` and advances `wr_ptr` by 1.
- Push while full with a simultaneous pop is accepted. The freed slot is reused, and `count` stays at DEPTH.
- Drop: `in_valid & full & !pop`. The data is discarded, the FIFO state is unchanged, and `drop_cnt` increments, holding at 255.
- Count next-state:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Show-ahead output:
  - `out_data = mem[rd_ptr]` (combinational from registers).
  - `out_valid = !empty`.
  - No bypass from input to output.
- Accumulator, in priority order:
  1. `acc_clr & push`: `acc` ← zero-extended `in_data`.
  2. `acc_clr` alone: `acc` ← 0.
  3. `push` alone: `acc` ← `acc` + zero-extended `in_data`, wrapping modulo 2^ACC_W.
  4. Dropped results never touch `acc`.
- Control is pointer/count based; no separate FSM. The equivalent states are EMPTY, PARTIAL and FULL, with transitions as implied by `count`.

## Timing
- Reset (async assert, takes effect immediately):
  - `wr_ptr`, `rd_ptr`, `count`, `drop_cnt` and `acc` go to 0.
  - Outputs: `out_valid`=0, `empty`=1, `full`=0, `count`=0, `drop_cnt`=0, `acc`=0.
  - Memory contents need not be cleared; `out_data` is don't-care while empty.
- Reset mid-operation: all stored entries are discarded and `out_valid` falls in the same cycle. No pop or push is counted on the edge on which reset is active.
- Release: the first push is possible on the first rising edge after `rst` deasserts.
- Latency: a result pushed on edge N is visible at `out_valid`/`out_data` after edge N, i.e. poppable at edge N+1. Minimum input-to-output latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained, in any state.
- `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_ready` while empty has no effect; the pointers are unchanged.
- `full`, `empty`, `count`, `drop_cnt` and `acc` are all registered-state derived, with no combinational path from `in_valid`.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. FIFO order is preserved across the wrap.

## Test plan
- Reset then single result: `in_valid`=1 with `in_data`=0x123 for one cycle, `out_ready`=0.
  - Required: next cycle `out_valid`=1, `out_data`=0x123, `count`=1, `acc`=0x123.
  - Then `out_ready`=1 for one cycle → `empty`=1.
- Fill and drop: 6 back-to-back pushes of 1,2,3,4,5,6 with `out_ready`=0 (DEPTH=4).
  - Required: `full`=1, `count`=4, `drop_cnt`=2, `acc`=10.
  - Draining then yields 1,2,3,4 in order.
- Full with simultaneous push/pop: FIFO holds 1..4, then `in_valid`=1 with 9 and `out_ready`=1.
  - Required: `count` stays 4 and `drop_cnt` is unchanged.
  - Drain order is 2,3,4,9.
- Wrap-around streaming: 20 consecutive pushes of 0..19 with `out_ready`=1 every cycle.
  - Required: outputs are 0..19 in order, each one cycle after its push; `count` never exceeds 1; `acc`=190.
- Accumulator clear and wrap, with ACC_W=W=10:
  - Push 0x3FF twice → `acc`=0x3FE.
  - `acc_clr` together with a push of 5 → `acc`=5.
  - `acc_clr` alone → `acc`=0.
- Async reset mid-operation: assert `rst` between edges with `count`=3 and `drop_cnt`=7.
  - Required: `out_valid`=0, `count`=0, `drop_cnt`=0 and `acc`=0 immediately.
  - After release, one push of 0x055 → `out_data`=0x055 and `count`=1.
